// File: rtl/input_debouncer_pkg.sv
// Shared board constants for the DE0-CV key/switch front end.
// The debounce window is sized for the 50 MHz board clock.
package input_debouncer_pkg;

   localparam int BOARD_DEBOUNCE_CYCLES = 1000000;
   localparam int BOARD_INPUT_WIDTH     = 14;

   function automatic int cnt_width(input int cycles);
      return $clog2(cycles);
   endfunction

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// One debounced input: 2-flop synchronizer, stability counter, accepted level
// and registered rise/fall pulses.
module debounce_bit
   import input_debouncer_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
   parameter logic RESET_VALUE     = 1'b0
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   // The counter tracks how long s2 has disagreed with the accepted level;
   // any agreement restarts it, so a single-cycle glitch never accumulates.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         s1    <= RESET_VALUE;
         s2    <= RESET_VALUE;
         level <= RESET_VALUE;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         rise <= 1'b0;
         fall <= 1'b0;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= s2;
            cnt   <= '0;
            rise  <= s2;
            fall  <= ~s2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/input_debouncer.sv
// Debounces WIDTH independent board inputs and flags any accepted change.
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter int               WIDTH           = BOARD_INPUT_WIDTH,
   parameter int               DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] debounced,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VALUE     (RESET_VALUE[i])
      ) u_bit (
         .clk_sys (CLOCK_50),
         .rst_b   (RESET_N),
         .raw     (raw_in[i]),
         .level   (debounced[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
      );
   end

   // Built only from registered pulses, so raw_in never reaches this output.
   assign changed = |(rise | fall);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with a 4-cycle window on 4 inputs.
module tb_input_debouncer;

   logic       clk_sys = 1'b0;
   logic       rst_b   = 1'b0;
   logic [3:0] raw_in  = 4'b0000;
   logic [3:0] debounced;
   logic [3:0] rise;
   logic [3:0] fall;
   logic       changed;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] raw;
      logic [3:0] deb;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       chg;
   } vec_t;

   vec_t vecs[$];

   input_debouncer #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4),
      .RESET_VALUE     (4'b0000)
   ) dut (
      .CLOCK_50  (clk_sys),
      .RESET_N   (rst_b),
      .raw_in    (raw_in),
      .debounced (debounced),
      .rise      (rise),
      .fall      (fall),
      .changed   (changed)
   );

   always #5 clk_sys = ~clk_sys;

   function automatic void add(input logic [3:0] raw, input logic [3:0] deb,
                               input logic [3:0] r, input logic [3:0] f, input logic c);
      vec_t v;
      v.raw  = raw;
      v.deb  = deb;
      v.rise = r;
      v.fall = f;
      v.chg  = c;
      vecs.push_back(v);
   endfunction

   // Edge E samples the new value; the edges E..E+4 show the old level and
   // E+5 shows the new level with a one-cycle pulse.
   function automatic void add_change(input logic [3:0] raw, input logic [3:0] old_deb,
                                      input logic [3:0] r, input logic [3:0] f);
      for (int k = 0; k < 5; k++) add(raw, old_deb, 4'b0000, 4'b0000, 1'b0);
      add(raw, raw, r, f, 1'b1);
      add(raw, raw, 4'b0000, 4'b0000, 1'b0);
   endfunction

   task automatic check(input string name, input logic [3:0] d, input logic [3:0] r,
                        input logic [3:0] f, input logic c);
      n_vec++;
      if (debounced !== d || rise !== r || fall !== f || changed !== c) begin
         n_err++;
         $display("FAIL %s: got deb=%b rise=%b fall=%b chg=%b, want deb=%b rise=%b fall=%b chg=%b",
                  name, debounced, rise, fall, changed, d, r, f, c);
      end
   endtask

   initial begin
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add_change(4'b0001, 4'b0000, 4'b0001, 4'b0000);
      add_change(4'b0000, 4'b0001, 4'b0000, 4'b0001);
      add_change(4'b1111, 4'b0000, 4'b1111, 4'b0000);
      add_change(4'b0000, 4'b1111, 4'b0000, 4'b1111);
      // Glitch: three high, one low, three high -- never four stable cycles.
      for (int k = 0; k < 3; k++) add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      for (int k = 0; k < 3; k++) add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      for (int k = 0; k < 6; k++) add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      #2;
      check("reset_state", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      @(negedge clk_sys);
      rst_b = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_sys);
         raw_in = vecs[i].raw;
         @(posedge clk_sys);
         #1;
         check($sformatf("vec%0d", i), vecs[i].deb, vecs[i].rise, vecs[i].fall, vecs[i].chg);
      end

      for (int i = 0; i < 100; i++) begin
         @(negedge clk_sys);
         raw_in = (i % 2 == 0) ? 4'b1111 : 4'b0000;
         @(posedge clk_sys);
         #1;
         check($sformatf("toggle%0d", i), 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end
      @(negedge clk_sys);
      raw_in = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_sys);
         #1;
         check("toggle_settle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end

      // Reset mid-count: bit 2 held high, counter reaches 2 after edge E+3.
      @(negedge clk_sys);
      raw_in = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_sys);
         #1;
         check("pre_reset_count", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end
      @(negedge clk_sys);
      rst_b = 1'b0;
      #1;
      check("reset_assert", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk_sys);
         #1;
         check("reset_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end
      @(negedge clk_sys);
      rst_b = 1'b1;
      #1;
      check("reset_release", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_sys);
         #1;
         check($sformatf("post_reset_wait%0d", i), 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end
      @(posedge clk_sys);
      #1;
      check("post_reset_accept", 4'b0100, 4'b0100, 4'b0000, 1'b1);
      @(posedge clk_sys);
      #1;
      check("post_reset_quiet", 4'b0100, 4'b0000, 4'b0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 14, number of independent raw inputs (4 keys + 10 switches).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles needed to accept a change (20 ms at 50 MHz); legal range is 2 or more.
REQ-003 SHALL have parameter RESET_VALUE, default all zeros, WIDTH bits, value of debounced state after reset.
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port raw_in, input, WIDTH bits: asynchronous board inputs (KEY, SW), already polarity-corrected by the instantiator.
REQ-007 SHALL have port debounced, output, WIDTH bits: accepted stable level per bit.
REQ-008 SHALL have port rise, output, WIDTH bits: one-cycle pulse per bit when debounced goes 0->1.
REQ-009 SHALL have port fall, output, WIDTH bits: one-cycle pulse per bit when debounced goes 1->0.
REQ-010 SHALL have port changed, output, 1 bit: OR of all rise and fall bits in the same cycle.

Function
REQ-011 SHALL pass each raw_in bit through a 2-flop synchronizer (s1, s2); no other logic sees raw_in.
REQ-012 SHALL keep, per bit, a counter of width clog2(DEBOUNCE_CYCLES); the counter saturates-free because of REQ-014.
REQ-013 Per bit, each cycle: if s2 == debounced, counter SHALL be cleared to 0.
REQ-014 Per bit, each cycle: if s2 != debounced and counter == DEBOUNCE_CYCLES-1, debounced SHALL take s2, counter SHALL clear, and rise or fall SHALL assert for exactly that next cycle.
REQ-015 Per bit, each cycle: if s2 != debounced and counter < DEBOUNCE_CYCLES-1, counter SHALL increment by 1.
REQ-016 Latency: raw_in first sampled new at edge E and held SHALL produce debounced update and pulse after edge E+DEBOUNCE_CYCLES+1, no earlier, no later.
REQ-017 Any single-cycle return of s2 to the debounced level SHALL restart the count from 0 (glitch rejection).
REQ-018 Bits SHALL be fully independent; simultaneous changes on several bits SHALL each pulse independently, and changed SHALL be a single 1 in that cycle.
REQ-019 rise and fall for one bit SHALL never both be 1; pulses SHALL be registered outputs, with no combinational path from raw_in.

Reset
REQ-020 On RESET_N low, asynchronously: s1, s2 and debounced SHALL be RESET_VALUE, all counters 0, rise/fall/changed 0.
REQ-021 Reset asserted mid-count SHALL discard the count; no pulse SHALL be generated by reset assertion or release.
REQ-022 After release, a raw_in differing from RESET_VALUE SHALL be accepted per REQ-016 timing, counted from the first sampling edge after release.

Structure
REQ-023 The DEBOUNCE_CYCLES default for 50 MHz and the WIDTH default for the DE0-CV key+switch set SHALL live in the shared board constants include, not in the module.
REQ-024 A per-bit sub-module debounce_bit (synchronizer, counter, level, rise/fall) SHALL be instantiated WIDTH times via generate; input_debouncer SHALL only replicate it and form changed.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4, RESET_VALUE=0)
REQ-025 raw_in[0] 0->1 sampled at edge E, held -> debounced[0]=1 and rise[0]=1 for one cycle after edge E+5; changed=1 same cycle.
REQ-026 raw_in[1] high 3 cycles, low 1 cycle, high 3 cycles -> no change on debounced[1], no pulses.
REQ-027 raw_in=4'b1111 in one cycle, later 4'b0000 -> rise=4'b1111 one cycle, later fall=4'b1111 one cycle; changed single pulse each time.
REQ-028 RESET_N low at counter=2 with raw_in[2]=1, released with raw_in[2]=1 held -> debounced[2] rises 5 edges after the first post-release sampling edge; no pulse at reset.
REQ-029 raw_in toggling every cycle for 100 cycles -> debounced stays RESET_VALUE, rise=fall=0 throughout.
